// File: rtl/vga_fade_sequencer_if.sv
// Bundles the timing-generator inputs, fade commands and scaler-side outputs of vga_fade_sequencer.
// test_sel exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_fade_sequencer_if;
  logic       h_active;
  logic       v_active;
  logic       hsync_i;
  logic       vsync_i;
  logic       frame_start;
  logic [5:0] pix_rgb;
  logic       fade_in_req;
  logic       fade_out_req;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_sel;
`endif
  logic       scaler_en;
  logic [1:0] r_d;
  logic [1:0] g_d;
  logic [1:0] b_d;
  logic       hsync_o;
  logic       vsync_o;
  logic [1:0] level;
  logic       busy;

  modport master (
    output h_active, v_active, hsync_i, vsync_i, frame_start, pix_rgb,
           fade_in_req, fade_out_req,
`ifdef VGA_TEST_PATTERN_EN
           test_sel,
`endif
    input  scaler_en, r_d, g_d, b_d, hsync_o, vsync_o, level, busy
  );

  modport slave (
    input  h_active, v_active, hsync_i, vsync_i, frame_start, pix_rgb,
           fade_in_req, fade_out_req,
`ifdef VGA_TEST_PATTERN_EN
           test_sel,
`endif
    output scaler_en, r_d, g_d, b_d, hsync_o, vsync_o, level, busy
  );
endinterface

// File: rtl/vga_fade_sequencer.sv
// VGA output sequencer: 2-stage pixel/sync pipeline, shared scaler enable and frame-synchronous fade.
// Optional macro VGA_TEST_PATTERN_EN adds a column-counter colour-bar source selected by test_sel.
module vga_fade_sequencer #(
  parameter int FRAMES_PER_STEP = 4,
  parameter int FCNT_W          = 8,
  parameter bit SYNC_ACTIVE     = 1'b0,
  parameter int PAT_SHIFT       = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  vga_fade_sequencer_if.slave bus
);
  typedef enum logic [1:0] {OFF, FADE_IN, ON, FADE_OUT} state_t;

  localparam logic [FCNT_W-1:0] STEP_LAST = FCNT_W'(FRAMES_PER_STEP - 1);

  state_t            state, state_nx;
  logic [1:0]        level, level_nx;
  logic [FCNT_W-1:0] fcnt, fcnt_nx;
  logic              want_in, want_out, step;

  // fade_out has priority when both requests arrive together
  assign want_out = bus.fade_out_req;
  assign want_in  = bus.fade_in_req & ~bus.fade_out_req;
  assign step     = bus.frame_start && (fcnt == STEP_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= OFF;
      level <= 2'd0;
      fcnt  <= '0;
    end else begin
      state <= state_nx;
      level <= level_nx;
      fcnt  <= fcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    level_nx = level;
    fcnt_nx  = fcnt;
    case (state)
      OFF: if (want_in) begin
        state_nx = FADE_IN;
        fcnt_nx  = '0;
      end
      ON: if (want_out) begin
        state_nx = FADE_OUT;
        fcnt_nx  = '0;
      end
      FADE_IN: begin
        if (want_out) begin
          state_nx = FADE_OUT;
          fcnt_nx  = '0;
        end else if (bus.frame_start) begin
          if (step) begin
            fcnt_nx  = '0;
            level_nx = level + 2'd1;
            if (level == 2'd2) state_nx = ON;
          end else begin
            fcnt_nx = fcnt + 1'b1;
          end
        end
      end
      FADE_OUT: begin
        if (want_in) begin
          state_nx = FADE_IN;
          fcnt_nx  = '0;
        end else if (bus.frame_start) begin
          if (step) begin
            fcnt_nx  = '0;
            level_nx = level - 2'd1;
            if (level == 2'd1) state_nx = OFF;
          end else begin
            fcnt_nx = fcnt + 1'b1;
          end
        end
      end
      default: state_nx = OFF;
    endcase
  end

  // Stage 1: raw input capture
  logic [5:0] s1_pix;
  logic       s1_h, s1_v, s1_hs, s1_vs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_pix <= '0;
      s1_h   <= 1'b0;
      s1_v   <= 1'b0;
      s1_hs  <= ~SYNC_ACTIVE;
      s1_vs  <= ~SYNC_ACTIVE;
    end else begin
      s1_pix <= bus.pix_rgb;
      s1_h   <= bus.h_active;
      s1_v   <= bus.v_active;
      s1_hs  <= bus.hsync_i;
      s1_vs  <= bus.vsync_i;
    end
  end

  logic [5:0] src;

`ifdef VGA_TEST_PATTERN_EN
  logic [10:0] col;
  logic        s1_tsel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col     <= '0;
      s1_tsel <= 1'b0;
    end else begin
      s1_tsel <= bus.test_sel;
      if (!s1_h)            col <= '0;
      else if (s1_h & s1_v) col <= col + 11'd1;
    end
  end

  assign src = s1_tsel ? col[PAT_SHIFT+5:PAT_SHIFT] : s1_pix;
`else
  assign src = s1_pix;
`endif

  // Saturating subtract of (3 - level); never wraps below zero
  function automatic logic [1:0] atten(input logic [1:0] d, input logic [1:0] sh);
    return (d > sh) ? d - sh : 2'd0;
  endfunction

  logic [1:0] shift;
  logic       en_nx;
  logic [1:0] r_nx, g_nx, b_nx;

  assign shift = 2'd3 - level;
  assign en_nx = s1_h & s1_v & (state != OFF);
  assign r_nx  = en_nx ? atten(src[5:4], shift) : 2'd0;
  assign g_nx  = en_nx ? atten(src[3:2], shift) : 2'd0;
  assign b_nx  = en_nx ? atten(src[1:0], shift) : 2'd0;

  // Stage 2: scaler-facing registers
  logic       s2_en, s2_hs, s2_vs;
  logic [1:0] s2_r, s2_g, s2_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_en <= 1'b0;
      s2_r  <= 2'd0;
      s2_g  <= 2'd0;
      s2_b  <= 2'd0;
      s2_hs <= ~SYNC_ACTIVE;
      s2_vs <= ~SYNC_ACTIVE;
    end else begin
      s2_en <= en_nx;
      s2_r  <= r_nx;
      s2_g  <= g_nx;
      s2_b  <= b_nx;
      s2_hs <= s1_hs;
      s2_vs <= s1_vs;
    end
  end

  assign bus.scaler_en = s2_en;
  assign bus.r_d       = s2_r;
  assign bus.g_d       = s2_g;
  assign bus.b_d       = s2_b;
  assign bus.hsync_o   = s2_hs;
  assign bus.vsync_o   = s2_vs;
  assign bus.level     = level;
  assign bus.busy      = (state == FADE_IN) || (state == FADE_OUT);
endmodule
